// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port instruction memory between IF fetch and the loader.
// Optional exclusive loader lock is enabled by defining IMEM_ARB_LOCK_EN.
module imem_port_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        fetch_err,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_lock,
  output logic        ld_gnt,
  output logic        ld_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int          CW        = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [CW-1:0] r_wait_cnt;
  logic          r_mem_en, r_mem_we, r_ld_done;
  logic [31:0]   r_mem_addr, r_mem_wdata;
  logic          r_rd_pend, r_rd_err, r_fetch_valid, r_fetch_err;
  logic [31:0]   r_fetch_hold;
  logic          w_force_ld, w_lock, w_fetch_ok, w_ld_ok;

`ifdef IMEM_ARB_LOCK_EN
  assign w_lock = ld_lock && ld_req;
`else
  logic w_unused_lock;
  assign w_unused_lock = ld_lock;
  assign w_lock        = 1'b0;
`endif

  assign w_force_ld = ld_req && (r_wait_cnt == CW'(MAX_WAIT));
  assign w_fetch_ok = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= LAST_WORD);
  assign w_ld_ok    = (ld_addr[1:0] == 2'b00) && (ld_addr <= LAST_WORD);

  // Loader wins when forced, locked, or fetch is idle; otherwise fetch has priority.
  assign ld_gnt    = rst_n && ld_req && (w_force_ld || w_lock || !fetch_req);
  assign fetch_gnt = rst_n && fetch_req && !(w_force_ld || w_lock);

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign ld_done     = r_ld_done;
  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = r_fetch_err;
  // Read data only exists during the response cycle, so it is passed through then and held after.
  assign fetch_data  = r_fetch_valid ? (r_fetch_err ? 32'h0 : mem_rdata) : r_fetch_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_ld_done     <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_rd_err      <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_fetch_hold  <= 32'h0;
    end else begin
      if (!ld_req || ld_gnt)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != CW'(MAX_WAIT))
        r_wait_cnt <= r_wait_cnt + CW'(1);

      r_mem_en  <= (fetch_gnt && w_fetch_ok) || (ld_gnt && w_ld_ok);
      r_mem_we  <= ld_gnt;
      r_ld_done <= ld_gnt;
      if (fetch_gnt)
        r_mem_addr <= fetch_addr;
      else if (ld_gnt)
        r_mem_addr <= ld_addr;
      if (ld_gnt)
        r_mem_wdata <= ld_wdata;

      r_rd_pend     <= fetch_gnt;
      r_rd_err      <= fetch_gnt && !w_fetch_ok;
      r_fetch_valid <= r_rd_pend;
      r_fetch_err   <= r_rd_err;
      if (r_fetch_valid)
        r_fetch_hold <= fetch_data;
    end
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: byte memory model, reference word array and response scoreboard.
// Exercises the IMEM_ARB_LOCK_EN lock path when that macro is defined.
module tb_imem_port_arbiter;
  localparam int MEM_BYTES = 128;
  localparam int MAX_WAIT  = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fetch_req = 1'b0, ld_req = 1'b0, ld_lock = 1'b0;
  logic [31:0] fetch_addr = '0, ld_addr = '0, ld_wdata = '0;
  logic        fetch_gnt, fetch_valid, fetch_err, ld_gnt, ld_done, mem_en, mem_we;
  logic [31:0] fetch_data, mem_addr, mem_wdata, mem_rdata;

  imem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .ld_done(ld_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
  endfunction

  // Synchronous memory; a write and a later-cycle read are naturally ordered.
  logic [7:0]  mem_b [MEM_BYTES];
  logic [31:0] ref_w [MEM_BYTES/4];
  logic [6:0]  ma;
  assign ma = {mem_addr[6:2], 2'b00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_b[ma]      <= mem_wdata[31:24];
        mem_b[ma + 1]  <= mem_wdata[23:16];
        mem_b[ma + 2]  <= mem_wdata[15:8];
        mem_b[ma + 3]  <= mem_wdata[7:0];
      end else begin
        mem_rdata <= {mem_b[ma], mem_b[ma + 1], mem_b[ma + 2], mem_b[ma + 3]};
      end
    end
  end

  typedef struct { logic err; logic [31:0] data; } resp_t;
  resp_t       q[$];
  logic        exp_mem_en = 0, exp_we = 0, exp_ld_done = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, last_data = '0;
  int          tb_wait = 0;

  always @(negedge clk) begin
    resp_t r;
    logic  lock, e_ld, e_f;
    if (!rst_n) begin
      q.delete();
      exp_mem_en = 0; exp_we = 0; exp_ld_done = 0;
      exp_addr = '0; exp_wdata = '0; last_data = '0; tb_wait = 0;
    end else begin
      check_val("mem_en", mem_en, exp_mem_en);
      check_val("ld_done", ld_done, exp_ld_done);
      if (exp_mem_en) begin
        check_val("mem_we", mem_we, exp_we);
        check_val("mem_addr", mem_addr, exp_addr);
        if (exp_we) check_val("mem_wdata", mem_wdata, exp_wdata);
      end
      if (fetch_valid) begin
        if (q.size() == 0) check_val("spurious_valid", fetch_valid, 1'b0);
        else begin
          r = q.pop_front();
          check_val("fetch_err", fetch_err, r.err);
          check_val("fetch_data", fetch_data, r.data);
          last_data = r.data;
        end
      end else begin
        check_val("data_hold", fetch_data, last_data);
      end

      lock = 1'b0;
`ifdef IMEM_ARB_LOCK_EN
      lock = ld_lock && ld_req;
`endif
      e_ld = ld_req && (tb_wait == MAX_WAIT || lock || !fetch_req);
      e_f  = fetch_req && !e_ld;
      check_val("ld_gnt", ld_gnt, e_ld);
      check_val("fetch_gnt", fetch_gnt, e_f);
      if (!ld_req || e_ld) tb_wait = 0;
      else if (tb_wait < MAX_WAIT) tb_wait++;

      exp_ld_done = e_ld;
      exp_mem_en  = (e_f && legal(fetch_addr)) || (e_ld && legal(ld_addr));
      exp_we      = e_ld;
      exp_addr    = e_ld ? ld_addr : fetch_addr;
      exp_wdata   = ld_wdata;
      if (e_f) begin
        r.err  = !legal(fetch_addr);
        r.data = legal(fetch_addr) ? ref_w[fetch_addr[6:2]] : 32'h0;
        q.push_back(r);
      end
      if (e_ld && legal(ld_addr)) ref_w[ld_addr[6:2]] = ld_wdata;
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [31:0] la, input logic [31:0] lw, input logic lk);
    fetch_req = fr; fetch_addr = fa; ld_req = lr; ld_addr = la; ld_wdata = lw; ld_lock = lk;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lcnt, fcnt, first;
    bit seen;
    logic [31:0] w;
    for (int i = 0; i < MEM_BYTES/4; i++) begin
      w = 32'hC0DE_0000 | 32'(i * 4);
      ref_w[i] = w;
      {mem_b[4*i], mem_b[4*i+1], mem_b[4*i+2], mem_b[4*i+3]} = w;
    end

    // Reset values
    #1;
    check_val("rst_fetch_gnt", fetch_gnt, 0);
    check_val("rst_ld_gnt", ld_gnt, 0);
    check_val("rst_fetch_valid", fetch_valid, 0);
    check_val("rst_fetch_data", fetch_data, 32'h0);
    check_val("rst_fetch_err", fetch_err, 0);
    check_val("rst_ld_done", ld_done, 0);
    check_val("rst_mem_en", mem_en, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // Fetch-only stream
    drive(1, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h4, 0, 0, 0, 0);
    drive(1, 32'h8, 0, 0, 0, 0);
    idle(3);

    // Reset during an in-flight read
    drive(1, 32'hC, 0, 0, 0, 0);
    fetch_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_mem_en", mem_en, 0);
    check_val("midrst_fetch_valid", fetch_valid, 0);
    check_val("midrst_fetch_data", fetch_data, 32'h0);
    check_val("midrst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(4);

    // Starvation bound: loader forced every MAX_WAIT+1 cycles
    fetch_req = 1; fetch_addr = 32'h40; ld_req = 1; ld_addr = 32'h40; ld_wdata = 32'h5A5A_0040;
    lcnt = 0; fcnt = 0; first = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ld_gnt) begin lcnt++; if (first < 0) first = i; end
      if (fetch_gnt) fcnt++;
    end
    @(posedge clk); #1;
    check_val("starve_ld_count", 32'(lcnt), 32'd3);
    check_val("starve_first_ld", 32'(first), 32'd4);
    check_val("starve_fetch_count", 32'(fcnt), 32'd12);
    idle(3);

    // Illegal and boundary addresses
    drive(1, 32'h2, 0, 0, 0, 0);
    drive(1, 32'h80, 0, 0, 0, 0);
    drive(1, 32'h7C, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h80, 32'h1111_2222, 0);
    drive(0, 0, 1, 32'h7C, 32'h3333_4444, 0);
    drive(1, 32'h7C, 0, 0, 0, 0);
    idle(3);

    // Read-after-write
    drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    drive(1, 32'h10, 0, 0, 0, 0);
    fetch_req = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        check_val("raw_data", fetch_data, 32'hDEAD_BEEF);
        seen = 1;
        break;
      end
    end
    if (!seen) check_val("raw_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
    idle(2);

`ifdef IMEM_ARB_LOCK_EN
    fetch_req = 1; fetch_addr = 32'h20; ld_req = 1; ld_lock = 1; ld_addr = 32'h30; ld_wdata = 32'hABCD_0030;
    lcnt = 0; fcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ld_gnt) lcnt++;
      if (fetch_gnt) fcnt++;
    end
    @(posedge clk); #1;
    check_val("lock_ld_count", 32'(lcnt), 32'd8);
    check_val("lock_fetch_count", 32'(fcnt), 32'd0);
    ld_lock = 0;
    @(negedge clk);
    check_val("lock_release_fetch", fetch_gnt, 1'b1);
    @(posedge clk); #1;
`else
    fetch_req = 1; fetch_addr = 32'h20; ld_req = 1; ld_lock = 1; ld_addr = 32'h30; ld_wdata = 32'hABCD_0030;
    @(negedge clk);
    check_val("nolock_fetch_gnt", fetch_gnt, 1'b1);
    @(posedge clk); #1;
`endif
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
